// File: rtl/rv32i_alu.sv
// RV32I integer ALU and branch comparator for the multi-cycle core.
// Combinational by default; P_REG_OUT=1 adds one register stage on both outputs.
module rv32i_alu #(
  parameter int unsigned P_REG_OUT = 32'd0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_op,
  input  logic        i_sub,
  input  logic        i_arith_shift,
  input  logic [2:0]  i_branch_op,
  output logic [31:0] o_y,
  output logic        o_will_branch
);

  logic [4:0]  shamt_s;
  logic [32:0] diff_s;
  logic [31:0] sum_s;
  logic [31:0] srl_s;
  logic [31:0] sra_s;
  logic        eq_s;
  logic        ltu_s;
  logic        lt_s;
  logic [31:0] y_d;
  logic        will_branch_d;

  assign shamt_s = i_b[4:0];
  assign sum_s   = i_a + i_b;
  // One 33-bit subtractor serves SUB and both magnitude compares (bit 32 is the borrow).
  assign diff_s  = {1'b0, i_a} - {1'b0, i_b};
  assign eq_s    = (i_a == i_b);
  assign ltu_s   = diff_s[32];
  assign lt_s    = (i_a[31] != i_b[31]) ? i_a[31] : diff_s[32];
  assign srl_s   = i_a >> shamt_s;
  assign sra_s   = $signed(i_a) >>> shamt_s;

  // ALU result selected by funct3 and its modifiers
  always_comb begin
    y_d = 32'd0;
    case (i_op)
      3'b000:  y_d = i_sub ? diff_s[31:0] : sum_s;
      3'b001:  y_d = i_a << shamt_s;
      3'b010:  y_d = {31'd0, lt_s};
      3'b011:  y_d = {31'd0, ltu_s};
      3'b100:  y_d = i_a ^ i_b;
      3'b101:  y_d = i_arith_shift ? sra_s : srl_s;
      3'b110:  y_d = i_a | i_b;
      3'b111:  y_d = i_a & i_b;
      default: y_d = 32'd0;
    endcase
  end

  // Branch condition selected by the branch funct3; reserved codes never branch
  always_comb begin
    will_branch_d = 1'b0;
    case (i_branch_op)
      3'b000:  will_branch_d = eq_s;
      3'b001:  will_branch_d = ~eq_s;
      3'b100:  will_branch_d = lt_s;
      3'b101:  will_branch_d = ~lt_s;
      3'b110:  will_branch_d = ltu_s;
      3'b111:  will_branch_d = ~ltu_s;
      default: will_branch_d = 1'b0;
    endcase
  end

  if (P_REG_OUT != 32'd0) begin : g_reg
    logic [31:0] y_q;
    logic        will_branch_q;

    // Output stage; reset overrides the captured result
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        y_q           <= 32'd0;
        will_branch_q <= 1'b0;
      end else begin
        y_q           <= y_d;
        will_branch_q <= will_branch_d;
      end
    end

    assign o_y           = y_q;
    assign o_will_branch = will_branch_q;
  end else begin : g_comb
    // Clock and reset are intentionally unused in the combinational build.
    logic unused_s;
    assign unused_s      = i_clk ^ i_reset;
    assign o_y           = y_d;
    assign o_will_branch = will_branch_d;
  end

endmodule

// File: tb/tb_rv32i_alu.sv
// Scoreboard bench: drives a combinational and a registered rv32i_alu from one
// stimulus stream and checks both against a behavioural reference model.
module tb_rv32i_alu;

  typedef struct {
    logic [31:0] y;
    logic        br;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [2:0]  op = 3'd0;
  logic        sub = 1'b0;
  logic        ars = 1'b0;
  logic [2:0]  bop = 3'd0;
  logic [31:0] y_c, y_r;
  logic        br_c, br_r;

  exp_t q_c[$];
  exp_t q_r[$];
  exp_t mon_c, mon_r;
  int   checks = 0;
  int   errors = 0;
  bit   flush = 1'b0;

  always #5 clk = ~clk;

  rv32i_alu #(.P_REG_OUT(32'd0)) u_comb (
    .i_clk(clk), .i_reset(rst), .i_a(a), .i_b(b), .i_op(op), .i_sub(sub),
    .i_arith_shift(ars), .i_branch_op(bop), .o_y(y_c), .o_will_branch(br_c)
  );

  rv32i_alu #(.P_REG_OUT(32'd1)) u_reg (
    .i_clk(clk), .i_reset(rst), .i_a(a), .i_b(b), .i_op(op), .i_sub(sub),
    .i_arith_shift(ars), .i_branch_op(bop), .o_y(y_r), .o_will_branch(br_r)
  );

  // Signed order expressed as unsigned order with the sign bit flipped.
  function automatic bit ref_slt(input logic [31:0] x, input logic [31:0] z);
    return (x ^ 32'h8000_0000) < (z ^ 32'h8000_0000);
  endfunction

  function automatic logic [31:0] ref_y(input logic [31:0] x, input logic [31:0] z,
                                        input logic [2:0] f, input logic s, input logic ar);
    int unsigned sh;
    sh = z % 32;
    case (f)
      3'd0:    return s ? (x - z) : (x + z);
      3'd1:    return x << sh;
      3'd2:    return ref_slt(x, z) ? 32'd1 : 32'd0;
      3'd3:    return (x < z) ? 32'd1 : 32'd0;
      3'd4:    return x ^ z;
      3'd5:    return (ar && x[31]) ? ~((~x) >> sh) : (x >> sh);
      3'd6:    return x | z;
      3'd7:    return x & z;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_br(input logic [31:0] x, input logic [31:0] z, input logic [2:0] f);
    case (f)
      3'd0:    return x == z;
      3'd1:    return x != z;
      3'd4:    return ref_slt(x, z);
      3'd5:    return !ref_slt(x, z);
      3'd6:    return x < z;
      3'd7:    return !(x < z);
      default: return 1'b0;
    endcase
  endfunction

  // Apply one vector; the comb stream uses the directed constant when given.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input logic [2:0] top,
                       input logic tsub, input logic tars, input logic [2:0] tbop,
                       input logic trst, input bit dy, input logic [31:0] ey,
                       input bit db, input logic eb, input string nm);
    exp_t ec, er;
    logic [31:0] my;
    logic        mb;
    @(posedge clk);
    #1;
    a = ta; b = tb_; op = top; sub = tsub; ars = tars; bop = tbop; rst = trst;
    my = ref_y(ta, tb_, top, tsub, tars);
    mb = ref_br(ta, tb_, tbop);
    ec.y = dy ? ey : my;
    ec.br = db ? eb : mb;
    ec.name = nm;
    er.y = trst ? 32'd0 : my;
    er.br = trst ? 1'b0 : mb;
    er.name = nm;
    q_c.push_back(ec);
    q_r.push_back(er);
  endtask

  task automatic alu(input logic [31:0] ta, input logic [31:0] tb_, input logic [2:0] top,
                     input logic tsub, input logic tars, input logic [31:0] ey, input string nm);
    issue(ta, tb_, top, tsub, tars, 3'd0, 1'b0, 1'b1, ey, 1'b0, 1'b0, nm);
  endtask

  task automatic brc(input logic [31:0] ta, input logic [31:0] tb_, input logic [2:0] tbop,
                     input logic eb, input string nm);
    issue(ta, tb_, 3'd0, 1'b0, 1'b0, tbop, 1'b0, 1'b0, 32'd0, 1'b1, eb, nm);
  endtask

  // Monitor: comb results are visible in the issue cycle, registered ones a cycle later
  always @(negedge clk) begin
    if (q_c.size() > 0) begin
      mon_c = q_c.pop_front();
      checks = checks + 2;
      if (y_c !== mon_c.y) begin
        errors = errors + 1;
        $display("FAIL comb_y %s: got %h expected %h", mon_c.name, y_c, mon_c.y);
      end
      if (br_c !== mon_c.br) begin
        errors = errors + 1;
        $display("FAIL comb_br %s: got %b expected %b", mon_c.name, br_c, mon_c.br);
      end
    end
    if (q_r.size() >= 2 || (flush && q_r.size() > 0)) begin
      mon_r = q_r.pop_front();
      checks = checks + 2;
      if (y_r !== mon_r.y) begin
        errors = errors + 1;
        $display("FAIL reg_y %s: got %h expected %h", mon_r.name, y_r, mon_r.y);
      end
      if (br_r !== mon_r.br) begin
        errors = errors + 1;
        $display("FAIL reg_br %s: got %b expected %b", mon_r.name, br_r, mon_r.br);
      end
    end
  end

  initial begin
    logic [31:0] ra, rb;
    issue(32'd3, 32'd4, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 32'd7, 1'b0, 1'b0, "reset0");
    issue(32'd3, 32'd4, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 32'd7, 1'b0, 1'b0, "reset1");
    alu(32'd3, 32'd4, 3'd0, 1'b0, 1'b0, 32'd7, "release_add");
    alu(32'hFFFF_FFFF, 32'd1, 3'd0, 1'b0, 1'b0, 32'h0000_0000, "add_wrap");
    alu(32'hFFFF_FFFF, 32'd1, 3'd0, 1'b1, 1'b0, 32'hFFFF_FFFE, "sub_big");
    alu(32'd5, 32'd7, 3'd0, 1'b1, 1'b0, 32'hFFFF_FFFE, "sub_wrap");
    issue(32'd9, 32'd9, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 32'd18, 1'b0, 1'b0, "midreset");
    alu(32'h8000_0010, 32'h0000_0024, 3'd1, 1'b0, 1'b0, 32'h0000_0100, "sll_hi_ignored");
    alu(32'h8000_0010, 32'd4, 3'd5, 1'b0, 1'b0, 32'h0800_0001, "srl4");
    alu(32'h8000_0010, 32'd4, 3'd5, 1'b0, 1'b1, 32'hF800_0001, "sra4");
    alu(32'h8000_0010, 32'd0, 3'd1, 1'b0, 1'b0, 32'h8000_0010, "sll0");
    alu(32'h8000_0010, 32'hFFFF_FFE4, 3'd5, 1'b0, 1'b0, 32'h0800_0001, "srl_hi_ignored");
    alu(32'h8000_0000, 32'd31, 3'd5, 1'b0, 1'b1, 32'hFFFF_FFFF, "sra31");
    alu(32'h8000_0010, 32'd4, 3'd1, 1'b0, 1'b1, 32'h0000_0100, "sll_ars_ignored");
    alu(32'hFFFF_FFFF, 32'd1, 3'd2, 1'b0, 1'b0, 32'd1, "slt");
    alu(32'hFFFF_FFFF, 32'd1, 3'd3, 1'b0, 1'b0, 32'd0, "sltu");
    alu(32'hFFFF_FFFF, 32'd1, 3'd4, 1'b0, 1'b0, 32'hFFFF_FFFE, "xor");
    alu(32'hFFFF_FFFF, 32'd1, 3'd6, 1'b0, 1'b0, 32'hFFFF_FFFF, "or");
    alu(32'hFFFF_FFFF, 32'd1, 3'd7, 1'b0, 1'b0, 32'd1, "and");
    alu(32'hFFFF_FFFF, 32'd1, 3'd4, 1'b1, 1'b0, 32'hFFFF_FFFE, "xor_sub_ignored");
    brc(32'hFFFF_FFFF, 32'd1, 3'd0, 1'b0, "beq");
    brc(32'hFFFF_FFFF, 32'd1, 3'd1, 1'b1, "bne");
    brc(32'hFFFF_FFFF, 32'd1, 3'd4, 1'b1, "blt");
    brc(32'hFFFF_FFFF, 32'd1, 3'd5, 1'b0, "bge");
    brc(32'hFFFF_FFFF, 32'd1, 3'd6, 1'b0, "bltu");
    brc(32'hFFFF_FFFF, 32'd1, 3'd7, 1'b1, "bgeu");
    brc(32'h0000_1234, 32'h0000_1234, 3'd0, 1'b1, "beq_eq");
    brc(32'h0000_1234, 32'h0000_1234, 3'd5, 1'b1, "bge_eq");
    brc(32'h0000_1234, 32'h0000_1234, 3'd7, 1'b1, "bgeu_eq");
    brc(32'h0000_1234, 32'h0000_1234, 3'd2, 1'b0, "rsvd2");
    brc(32'hFFFF_FFFF, 32'd1, 3'd3, 1'b0, "rsvd3");

    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra ^ $urandom_range(0, 40) : $urandom;
      issue(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 99) == 0), 1'b0, 32'd0, 1'b0, 1'b0, "random");
    end

    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks = checks + 1;
    if (q_c.size() != 0 || q_r.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q_c.size(), q_r.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
